// File: rtl/mulq_arbiter.sv
// -----------------------------------------------------------------------------
// mulq_arbiter
//
// Shares one pipelined modular multiplier (c = a*b mod Q) among NREQ
// requesters. At most one operand pair is issued per cycle, chosen by
// round-robin. Each issue is tracked through the multiplier latency by a tag
// pipeline so the result can be routed back to its requester. A drain/halt
// handshake lets the multiplier be quiesced for reconfiguration.
//
// Parameters:
//   NREQ  number of requesters (2..4)
//   W     operand / result width
//   LAT   multiplier latency, from mul_a/mul_b sampled to mul_c valid (1..8)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   req_valid  in   [NREQ]    per-requester operand valid
//   req_ready  out  [NREQ]    one-hot grant (combinational)
//   req_a      in   [NREQ*W]  packed operand a, requester i at [i*W +: W]
//   req_b      in   [NREQ*W]  packed operand b, same packing
//   mul_a      out  [W]       registered operand a to the multiplier
//   mul_b      out  [W]       registered operand b to the multiplier
//   mul_c      in   [W]       multiplier result
//   rsp_valid  out  [NREQ]    one-hot result strobe, one cycle wide
//   rsp_data   out  [W]       result value, zero when rsp_valid == 0
//   drain_req  in   level request to stop issuing and empty the pipeline
//   halted     out  high while halted (pipeline empty, no issues)
//
// Optional build macro MULQ_ARB_STATS_EN adds:
//   stat_issues     out [32]  saturating count of transfers since reset
//   stat_conflicts  out [32]  saturating count of RUN cycles with >= 2 requests
// -----------------------------------------------------------------------------
module mulq_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 12,
    parameter int LAT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [W-1:0]      mul_c,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    input  logic              drain_req,
    output logic              halted
`ifdef MULQ_ARB_STATS_EN
    ,
    output logic [31:0]       stat_issues,
    output logic [31:0]       stat_conflicts
`endif
);

    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DEPTH = LAT + 1;
    localparam int CW    = $clog2(LAT + 2);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                       state_r;
    logic                         halted_r;
    logic [IDW-1:0]               rr_ptr_r;
    logic [W-1:0]                 mul_a_r;
    logic [W-1:0]                 mul_b_r;
    logic [DEPTH-1:0]             tag_vld_r;
    logic [DEPTH-1:0][IDW-1:0]    tag_id_r;
    logic [CW-1:0]                inflight_r;

    logic [2*NREQ-1:0]            rot_s;
    logic                         grant_any_s;
    logic [IDW:0]                 sel_s;
    logic [IDW:0]                 sum_s;
    logic [IDW-1:0]               grant_id_s;
    logic                         grant_en_s;
    logic                         xfer_s;
    logic                         tail_vld_s;
    logic [IDW-1:0]               tail_id_s;
    logic                         drain_done_s;
    logic [CW-1:0]                inflight_nxt_s;

    // Requester index to one-hot vector.
    function automatic logic [NREQ-1:0] id_to_onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] oh;
        oh = {{(NREQ-1){1'b0}}, 1'b1} << id;
        return oh;
    endfunction

    // Round-robin search: rotate the doubled request vector so that bit 0 is
    // the requester at rr_ptr, then pick the lowest set bit and rotate back.
    always_comb begin
        rot_s       = {req_valid, req_valid} >> rr_ptr_r;
        grant_any_s = 1'b0;
        sel_s       = {(IDW+1){1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                grant_any_s = 1'b1;
                sel_s       = (IDW+1)'(k);
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        sum_s = {1'b0, rr_ptr_r} + sel_s;
        if (sum_s >= (IDW+1)'(NREQ)) begin
            sum_s = sum_s - (IDW+1)'(NREQ);
        end else begin
            sum_s = sum_s;
        end
        grant_id_s = sum_s[IDW-1:0];
    end

    // Grants only in RUN; a rising drain_req suppresses the grant that cycle.
    always_comb begin
        grant_en_s = (state_r == ST_RUN) && !drain_req;
        xfer_s     = grant_en_s && grant_any_s;
        if (xfer_s) begin
            req_ready = id_to_onehot(grant_id_s);
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Response routing from the tail of the tag pipeline.
    always_comb begin
        tail_vld_s = tag_vld_r[DEPTH-1];
        tail_id_s  = tag_id_r[DEPTH-1];
        if (tail_vld_s) begin
            rsp_valid = id_to_onehot(tail_id_s);
            rsp_data  = mul_c;
        end else begin
            rsp_valid = {NREQ{1'b0}};
            rsp_data  = {W{1'b0}};
        end
    end

    // In-flight bookkeeping; the pipeline counts as empty once the last
    // entry is retiring in the current cycle.
    always_comb begin
        inflight_nxt_s = inflight_r + {{(CW-1){1'b0}}, xfer_s}
                                    - {{(CW-1){1'b0}}, tail_vld_s};
        drain_done_s   = (inflight_r == {CW{1'b0}}) ||
                         ((inflight_r == CW'(1'b1)) && tail_vld_s);
    end

    // Operand registers, round-robin pointer, tag pipeline and in-flight count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_r    <= {W{1'b0}};
            mul_b_r    <= {W{1'b0}};
            rr_ptr_r   <= {IDW{1'b0}};
            tag_vld_r  <= {DEPTH{1'b0}};
            tag_id_r   <= {(DEPTH*IDW){1'b0}};
            inflight_r <= {CW{1'b0}};
        end else begin
            if (xfer_s) begin
                mul_a_r <= req_a[grant_id_s*W +: W];
                mul_b_r <= req_b[grant_id_s*W +: W];
                if (grant_id_s == IDW'(NREQ - 1)) begin
                    rr_ptr_r <= {IDW{1'b0}};
                end else begin
                    rr_ptr_r <= grant_id_s + IDW'(1'b1);
                end
            end else begin
                mul_a_r  <= mul_a_r;
                mul_b_r  <= mul_b_r;
                rr_ptr_r <= rr_ptr_r;
            end
            tag_vld_r  <= {tag_vld_r[DEPTH-2:0], xfer_s};
            tag_id_r   <= {tag_id_r[DEPTH-2:0], (xfer_s ? grant_id_s : {IDW{1'b0}})};
            inflight_r <= inflight_nxt_s;
        end
    end

    // Drain/halt state machine with registered halted flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (drain_req) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                    halted_r <= 1'b0;
                end
                ST_DRAIN: begin
                    if (!drain_req) begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end else if (drain_done_s) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_DRAIN;
                        halted_r <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (!drain_req) begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign mul_a  = mul_a_r;
    assign mul_b  = mul_b_r;
    assign halted = halted_r;

`ifdef MULQ_ARB_STATS_EN
    logic [31:0] stat_issues_r;
    logic [31:0] stat_conflicts_r;
    logic        conflict_s;

    // A conflict is any RUN cycle with two or more requesters asking.
    always_comb begin
        conflict_s = (state_r == ST_RUN) && ($countones(req_valid) >= 2);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issues_r    <= 32'd0;
            stat_conflicts_r <= 32'd0;
        end else begin
            if (xfer_s && (stat_issues_r != 32'hFFFF_FFFF)) begin
                stat_issues_r <= stat_issues_r + 32'd1;
            end else begin
                stat_issues_r <= stat_issues_r;
            end
            if (conflict_s && (stat_conflicts_r != 32'hFFFF_FFFF)) begin
                stat_conflicts_r <= stat_conflicts_r + 32'd1;
            end else begin
                stat_conflicts_r <= stat_conflicts_r;
            end
        end
    end

    assign stat_issues    = stat_issues_r;
    assign stat_conflicts = stat_conflicts_r;
`endif

endmodule

// File: tb/tb_mulq_arbiter.sv
// Testbench for mulq_arbiter: behavioural mod-3329 multiplier, requester
// queues, a reference model that predicts grants and responses, and a
// scoreboard monitor that checks every result strobe.
module tb_mulq_arbiter;
    localparam int NREQ = 2;
    localparam int W    = 12;
    localparam int LAT  = 3;
    localparam int Q    = 3329;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W-1:0]      mul_c;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              drain_req;
    logic              halted;
`ifdef MULQ_ARB_STATS_EN
    logic [31:0]       stat_issues;
    logic [31:0]       stat_conflicts;
`endif

    mulq_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .drain_req(drain_req), .halted(halted)
`ifdef MULQ_ARB_STATS_EN
        , .stat_issues(stat_issues), .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: samples operands each edge, result LAT edges later.
    logic [W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= W'((int'(mul_a) * int'(mul_b)) % Q);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_c = mpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int due;
        int id;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   infl_q[$];
    int   resp_cnt[NREQ];
    int   sq_a[NREQ][$];
    int   sq_b[NREQ][$];
    logic [NREQ-1:0] mdl_gnt;

    // Reference model state (0 = run, 1 = drain, 2 = halt).
    int mode = 0;
    int rr   = 0;
    int g, idx, cnt;
    logic [NREQ-1:0] exp_rdy;

    // Reference model: predicts the grant for this cycle, queues the expected
    // product for the cycle it must come back, then advances the mode.
    always @(negedge clk) begin
        if (rst) begin
            mode = 0;
            rr = 0;
            infl_q.delete();
            mdl_gnt = '0;
            chk("ready_in_reset", req_ready, 0);
            chk("halted_in_reset", halted, 0);
        end else begin
            while (infl_q.size() > 0 && infl_q[0] < cyc) void'(infl_q.pop_front());
            cnt = infl_q.size();
            exp_rdy = '0;
            g = -1;
            if (mode == 0 && !drain_req) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (rr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("halted", halted, (mode == 2) ? 1 : 0);
            if (g >= 0) begin
                exp_q.push_back('{cyc + 1 + LAT, g,
                    (int'(req_a[g*W +: W]) * int'(req_b[g*W +: W])) % Q});
                infl_q.push_back(cyc + 1 + LAT);
                rr = (g + 1) % NREQ;
            end
            mdl_gnt = exp_rdy;
            case (mode)
                0: if (drain_req) mode = 1;
                1: begin
                    if (!drain_req) mode = 0;
                    else if (cnt == 0 || (cnt == 1 && infl_q[0] == cyc)) mode = 2;
                end
                2: if (!drain_req) mode = 0;
                default: mode = 0;
            endcase
        end
    end

    // Scoreboard monitor: a result must appear exactly when due, else silence.
    exp_t e;
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rsp_valid", rsp_valid, 1 << e.id);
            chk("rsp_data", rsp_data, e.data);
            resp_cnt[e.id]++;
        end else begin
            chk("rsp_idle", rsp_valid, 0);
        end
    end

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = (sq_a[i].size() > 0);
            req_a[i*W +: W]    = (sq_a[i].size() > 0) ? W'(sq_a[i][0]) : '0;
            req_b[i*W +: W]    = (sq_b[i].size() > 0) ? W'(sq_b[i][0]) : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (mdl_gnt[i] && sq_a[i].size() > 0) begin
                void'(sq_a[i].pop_front());
                void'(sq_b[i].pop_front());
            end
        end
        apply();
    endtask

    task automatic push(input int r, input int a, input int b);
        sq_a[r].push_back(a);
        sq_b[r].push_back(b);
    endtask

    task automatic check_outputs_zero();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_halted", halted, 0);
    endtask

    int b0, b1, n;

    initial begin
        rst = 1'b1;
        drain_req = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero();
        rst = 1'b0;
        repeat (2) step();

        // Single request
        push(0, 10, 5);
        repeat (8) step();

        // Contention
        push(0, 1234, 2000);
        push(1, 3000, 3000);
        repeat (8) step();

        // Fairness: both held valid for 8 cycles
        b0 = resp_cnt[0];
        b1 = resp_cnt[1];
        for (int k = 0; k < 4; k++) begin
            push(0, int'($urandom_range(Q - 1, 0)), int'($urandom_range(Q - 1, 0)));
            push(1, int'($urandom_range(Q - 1, 0)), int'($urandom_range(Q - 1, 0)));
        end
        repeat (14) step();
        chk("fair_resp_req0", resp_cnt[0] - b0, 4);
        chk("fair_resp_req1", resp_cnt[1] - b1, 4);

        // Drain after three back-to-back issues
        b0 = resp_cnt[0];
        for (int k = 0; k < 3; k++) push(0, 100 + k, 7 + k);
        repeat (4) step();
        drain_req = 1'b1;
        push(1, 55, 66);
        apply();
        n = 0;
        while (!halted && n < 20) begin
            step();
            n++;
        end
        chk("drain_halted_reached", halted, 1);
        chk("drain_all_delivered", resp_cnt[0] - b0, 3);
        repeat (2) step();
        drain_req = 1'b0;
        repeat (8) step();

        // Reset mid-flight
        push(0, 321, 123);
        push(1, 2222, 3333 - 5);
        repeat (3) step();
        rst = 1'b1;
        sq_a[0].delete(); sq_b[0].delete();
        sq_a[1].delete(); sq_b[1].delete();
        apply();
        #1;
        check_outputs_zero();
        step();
        rst = 1'b0;
        repeat (6) step();

        // Contention again from a clean reset
        push(0, 1234, 2000);
        push(1, 3000, 3000);
        repeat (8) step();
`ifdef MULQ_ARB_STATS_EN
        chk("stat_issues", stat_issues, 2);
        chk("stat_conflicts", stat_conflicts, 1);
`endif

        // Randomized traffic with drain toggling
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (sq_a[i].size() < 3 && $urandom_range(2, 0) == 0)
                    push(i, int'($urandom_range(Q - 1, 0)), int'($urandom_range(Q - 1, 0)));
            end
            if ($urandom_range(29, 0) == 0) drain_req = ~drain_req;
            step();
        end
        drain_req = 1'b0;
        n = 0;
        while ((sq_a[0].size() + sq_a[1].size() + exp_q.size()) > 0 && n < 40) begin
            step();
            n++;
        end
        repeat (2) step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
